// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (I)
// and load/store (D); one transaction in flight, with a WAIT-state timeout.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_done,
  input  logic                d_req,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W/8-1:0] d_we,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_done,
  output logic                m_req,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W/8-1:0] m_we,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_done,
  output logic                err_timeout
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

  state_t          state_q, state_d;
  owner_t          owner_q, grant_owner, last_q;
  logic            grant;
  logic            timed_out;
  logic [7:0]      cnt_q;
  logic [BE_W-1:0] we_q;

  always_comb begin
    state_d     = state_q;
    grant       = 1'b0;
    grant_owner = owner_q;
    timed_out   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_req && d_req) begin
          grant       = 1'b1;
          grant_owner = (last_q == OWN_I) ? OWN_D : OWN_I;
        end else if (d_req) begin
          grant       = 1'b1;
          grant_owner = OWN_D;
        end else if (i_req) begin
          grant       = 1'b1;
          grant_owner = OWN_I;
        end
        if (grant) state_d = S_ISSUE;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        // A response arriving on the timeout cycle still counts as a success
        timed_out = !m_done && (cnt_q == TIMEOUT_CNT);
        if (m_done || timed_out) state_d = S_RESP;
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_I;
      last_q      <= OWN_I;
      cnt_q       <= '0;
      we_q        <= '0;
      m_addr      <= '0;
      m_wdata     <= '0;
      i_rdata     <= '0;
      d_rdata     <= '0;
      err_timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q <= grant_owner;
        last_q  <= grant_owner;
        if (grant_owner == OWN_D) begin
          m_addr  <= d_addr;
          we_q    <= d_we;
          m_wdata <= d_wdata;
        end else begin
          m_addr  <= i_addr;
          we_q    <= '0;
          m_wdata <= '0;
        end
      end
      if (state_q == S_ISSUE) cnt_q <= '0;
      // Read data goes straight into the owner's output register so it is valid in RESP
      if (state_q == S_WAIT) begin
        if (m_done || timed_out) begin
          if (owner_q == OWN_I) begin
            i_rdata <= m_done ? m_rdata : '0;
          end else if (we_q == '0) begin
            d_rdata <= m_done ? m_rdata : '0;
          end
          if (timed_out) err_timeout <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end
    end
  end

  assign m_req  = (state_q == S_ISSUE);
  assign m_we   = m_req ? we_q : '0;
  assign i_done = (state_q == S_RESP) && (owner_q == OWN_I);
  assign d_done = (state_q == S_RESP) && (owner_q == OWN_D);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter with a latency-programmable
// memory responder and a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        d_req = 1'b0;
  logic [31:0] d_addr = '0;
  logic [3:0]  d_we = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        m_req;
  logic [31:0] m_addr;
  logic [3:0]  m_we;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata_m = '0;
  logic        m_done_m = 1'b0;
  logic        inj_done = 1'b0;
  logic        err_timeout;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .m_req(m_req), .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata),
    .m_rdata(m_rdata_m), .m_done(m_done_m | inj_done),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  logic [31:0] key;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0], a[31:16]} ^ key;
  endfunction

  // Memory responder: answers L cycles after seeing m_req; ignores rst on purpose
  int          mem_lat = 1;
  bit          mem_silent = 1'b0;
  bit          mbusy = 1'b0;
  int          mcnt = 0;
  logic [31:0] maddr = '0;
  int          mreq_cnt = 0;
  logic [31:0] log_addr = '0;
  logic [3:0]  log_we = '0;
  logic [31:0] log_wdata = '0;

  always @(posedge clk) begin
    m_done_m <= 1'b0;
    if (m_req) begin
      mreq_cnt++;
      log_addr  = m_addr;
      log_we    = m_we;
      log_wdata = m_wdata;
    end
    if (m_req && !mem_silent) begin
      if (mem_lat == 1) begin
        m_done_m  <= 1'b1;
        m_rdata_m <= mem_data(m_addr);
      end else begin
        mbusy = 1'b1;
        mcnt  = mem_lat - 1;
        maddr = m_addr;
      end
    end else if (mbusy) begin
      if (mcnt == 1) begin
        m_done_m  <= 1'b1;
        m_rdata_m <= mem_data(maddr);
        mbusy = 1'b0;
      end else begin
        mcnt--;
      end
    end
  end

  int   i_done_cnt = 0;
  int   d_done_cnt = 0;
  int   both_cnt = 0;
  int   we_viol = 0;
  int   wide_req = 0;
  logic m_req_prev = 1'b0;

  always @(negedge clk) begin
    if (i_done) i_done_cnt++;
    if (d_done) d_done_cnt++;
    if (i_done && d_done) both_cnt++;
    if (!m_req && m_we != 4'h0) we_viol++;
    if (m_req && m_req_prev) wide_req++;
    m_req_prev = m_req;
  end

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issues one request and returns the number of edges until its done is visible
  task automatic do_txn(input bit is_d, input logic [31:0] a, input logic [3:0] we,
                        input logic [31:0] wd, input int lat, input bit silent,
                        output int cyc);
    mem_lat    = lat;
    mem_silent = silent;
    if (is_d) begin
      d_req = 1'b1; d_addr = a; d_we = we; d_wdata = wd;
    end else begin
      i_req = 1'b1; i_addr = a;
    end
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!(is_d ? d_done : i_done) && cyc < 1000);
    if (is_d) d_req = 1'b0;
    else i_req = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(2);
    checks++;
    if ({i_done, d_done, m_req, m_we, err_timeout} !== 8'h00) begin
      failures++;
      $display("FAIL reset_ctrl got=%h want=00", {i_done, d_done, m_req, m_we, err_timeout});
    end
    checks++;
    if ({i_rdata, d_rdata, m_addr, m_wdata} !== 128'h0) begin
      failures++;
      $display("FAIL reset_data got=%h want=0", {i_rdata, d_rdata, m_addr, m_wdata});
    end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_basic_fetch;
    int cyc;
    int r0, i0;
    r0 = mreq_cnt; i0 = i_done_cnt;
    do_txn(1'b0, 32'h100, 4'h0, 32'h0, 1, 1'b0, cyc);
    checks++;
    if (cyc !== 3) begin failures++; $display("FAIL fetch_latency got=%0d want=3", cyc); end
    checks++;
    if (i_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL fetch_rdata got=%h want=deadbeef", i_rdata); end
    checks++;
    if (log_addr !== 32'h100 || log_we !== 4'h0) begin
      failures++; $display("FAIL fetch_maddr got=%h/%h want=100/0", log_addr, log_we);
    end
    tick(1);
    checks++;
    if (mreq_cnt - r0 !== 1 || i_done_cnt - i0 !== 1 || i_done !== 1'b0) begin
      failures++;
      $display("FAIL fetch_pulses mreq=%0d done=%0d idone=%b want=1/1/0", mreq_cnt - r0, i_done_cnt - i0, i_done);
    end
  endtask

  task automatic test_store;
    int cyc;
    logic [31:0] prev;
    prev = d_rdata;
    do_txn(1'b1, 32'h40, 4'hF, 32'h12345678, 4, 1'b0, cyc);
    checks++;
    if (cyc !== 6) begin failures++; $display("FAIL store_latency got=%0d want=6", cyc); end
    checks++;
    if (log_addr !== 32'h40 || log_we !== 4'hF || log_wdata !== 32'h12345678) begin
      failures++;
      $display("FAIL store_mport got=%h/%h/%h want=40/f/12345678", log_addr, log_we, log_wdata);
    end
    checks++;
    if (d_rdata !== prev) begin failures++; $display("FAIL store_rdata got=%h want=%h", d_rdata, prev); end
    tick(1);
  endtask

  task automatic test_idle_mdone;
    int r0, i0, d0;
    logic [31:0] ir, dr;
    r0 = mreq_cnt; i0 = i_done_cnt; d0 = d_done_cnt; ir = i_rdata; dr = d_rdata;
    tick(2);
    inj_done = 1'b1;
    tick(1);
    inj_done = 1'b0;
    tick(4);
    checks++;
    if (mreq_cnt != r0 || i_done_cnt != i0 || d_done_cnt != d0 || i_rdata !== ir || d_rdata !== dr) begin
      failures++;
      $display("FAIL idle_mdone mreq=%0d idone=%0d ddone=%0d want=%0d/%0d/%0d", mreq_cnt, i_done_cnt, d_done_cnt, r0, i0, d0);
    end
  endtask

  task automatic test_timeout_boundary;
    int cyc;
    do_txn(1'b1, 32'h5550, 4'h0, 32'h0, TO + 1, 1'b0, cyc);
    checks++;
    if (cyc !== TO + 3) begin failures++; $display("FAIL edge_latency got=%0d want=%0d", cyc, TO + 3); end
    checks++;
    if (d_rdata !== mem_data(32'h5550) || err_timeout !== 1'b0) begin
      failures++;
      $display("FAIL edge_data got=%h err=%b want=%h err=0", d_rdata, err_timeout, mem_data(32'h5550));
    end
    tick(2);
  endtask

  task automatic test_random;
    int cyc, lat;
    bit is_d;
    logic [31:0] a, wd, exp_i, exp_d;
    logic [3:0] we;
    exp_i = i_rdata;
    exp_d = d_rdata;
    for (int n = 0; n < 30; n++) begin
      is_d = 1'($urandom_range(0, 1));
      a    = $urandom;
      wd   = $urandom;
      we   = (is_d && $urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      lat  = $urandom_range(1, 6);
      if (!is_d) exp_i = mem_data(a);
      else if (we == 4'h0) exp_d = mem_data(a);
      do_txn(is_d, a, we, wd, lat, 1'b0, cyc);
      checks++;
      if (cyc !== 2 + lat) begin failures++; $display("FAIL rand_latency n=%0d got=%0d want=%0d", n, cyc, 2 + lat); end
      checks++;
      if (i_rdata !== exp_i || d_rdata !== exp_d) begin
        failures++;
        $display("FAIL rand_rdata n=%0d got=%h/%h want=%h/%h", n, i_rdata, d_rdata, exp_i, exp_d);
      end
      checks++;
      if (log_addr !== a || log_we !== we || (is_d && log_wdata !== wd)) begin
        failures++;
        $display("FAIL rand_mport n=%0d got=%h/%h/%h want=%h/%h/%h", n, log_addr, log_we, log_wdata, a, we, wd);
      end
      tick($urandom_range(1, 2));
    end
  endtask

  task automatic test_fairness;
    bit last_d, exp_d, got_d;
    int dones, cyc;
    logic [31:0] ia, da;
    rst = 1'b1; tick(1); rst = 1'b0; tick(1);
    ia = 32'h1000 + ($urandom & 32'hFF0);
    da = 32'h2000 + ($urandom & 32'hFF0);
    mem_lat = $urandom_range(1, 3); mem_silent = 1'b0;
    i_req = 1'b1; i_addr = ia;
    d_req = 1'b1; d_addr = da; d_we = 4'h0; d_wdata = '0;
    last_d = 1'b0;
    dones = 0; cyc = 0;
    while (dones < 4 && cyc < 200) begin
      @(posedge clk); #1; cyc++;
      if (i_done || d_done) begin
        exp_d  = !last_d;
        last_d = exp_d;
        got_d  = d_done;
        checks++;
        if (got_d !== exp_d || (i_done && d_done)) begin
          failures++; $display("FAIL rr_order grant=%0d got_d=%b want_d=%b", dones, got_d, exp_d);
        end
        checks++;
        if (got_d ? (d_rdata !== mem_data(da)) : (i_rdata !== mem_data(ia))) begin
          failures++; $display("FAIL rr_rdata grant=%0d got=%h/%h", dones, i_rdata, d_rdata);
        end
        dones++;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    checks++;
    if (dones !== 4) begin failures++; $display("FAIL rr_count got=%0d want=4", dones); end
    tick(3);
    checks++;
    if (both_cnt !== 0 || we_viol !== 0 || wide_req !== 0) begin
      failures++; $display("FAIL port_rules both=%0d we=%0d wide=%0d want=0/0/0", both_cnt, we_viol, wide_req);
    end
  endtask

  task automatic test_timeout;
    int cyc;
    do_txn(1'b1, 32'h7000, 4'h0, 32'h0, 1, 1'b1, cyc);
    checks++;
    if (cyc !== TO + 3) begin failures++; $display("FAIL to_latency got=%0d want=%0d", cyc, TO + 3); end
    checks++;
    if (d_rdata !== 32'h0 || err_timeout !== 1'b1) begin
      failures++; $display("FAIL to_result got=%h err=%b want=0 err=1", d_rdata, err_timeout);
    end
    mem_silent = 1'b0;
    tick(5);
    checks++;
    if (err_timeout !== 1'b1) begin failures++; $display("FAIL to_sticky got=%b want=1", err_timeout); end
  endtask

  task automatic test_reset_mid;
    int i0, d0, cyc;
    mem_lat = 8; mem_silent = 1'b0;
    d_req = 1'b1; d_addr = 32'h3330; d_we = 4'h0;
    tick(3);
    i0 = i_done_cnt; d0 = d_done_cnt;
    rst = 1'b1;
    #1;
    checks++;
    if ({i_done, d_done, m_req, m_we, err_timeout, i_rdata, d_rdata, m_addr, m_wdata} !== '0) begin
      failures++; $display("FAIL midrst_outputs got=%h want=0", {i_done, d_done, m_req, m_we, err_timeout, m_addr});
    end
    d_req = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0;
    tick(10);
    checks++;
    if (i_done_cnt != i0 || d_done_cnt != d0) begin
      failures++; $display("FAIL midrst_nodone got=%0d/%0d want=%0d/%0d", i_done_cnt, d_done_cnt, i0, d0);
    end
    do_txn(1'b0, 32'h900, 4'h0, 32'h0, 1, 1'b0, cyc);
    checks++;
    if (cyc !== 3 || i_rdata !== mem_data(32'h900)) begin
      failures++; $display("FAIL midrst_after got=%0d/%h want=3/%h", cyc, i_rdata, mem_data(32'h900));
    end
    tick(2);
  endtask

  initial begin
    key = $urandom;
    test_reset;
    test_basic_fetch;
    test_store;
    test_idle_mdone;
    test_timeout_boundary;
    test_random;
    test_fairness;
    test_timeout;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
